// File: rtl/br_resolve_pipe.sv
// br_resolve_pipe: pipelined RV32I conditional-branch resolution unit.
//
// Evaluates beq/bne/blt/bge/bltu/bgeu on XLEN-bit operands, compares the
// outcome with the fetch prediction and produces a mispredict flag plus the
// redirect PC. Valid/ready handshake on both sides; LATENCY is 1 or 2.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               kill all in-flight entries (and the current input)
//   in_valid/in_ready   upstream handshake
//   a, b, cmpop         operands and branch funct3
//   pc, target          branch PC and computed branch target
//   pred_taken          fetch-stage prediction
//   out_valid/out_ready downstream handshake
//   br_en, mispredict   resolved direction, prediction mismatch
//   illegal             cmpop was 010 or 011
//   redirect_pc         br_en ? target : pc + 4 (wraps)
//
// Optional build macro BR_RESOLVE_STATS_EN adds saturating counters
// stat_branches / stat_mispredicts and the synchronous clear stat_clear.
module br_resolve_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      cmpop,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_en,
  output logic            mispredict,
  output logic            illegal,
  output logic [XLEN-1:0] redirect_pc
`ifdef BR_RESOLVE_STATS_EN
  ,
  input  logic            stat_clear,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  // Raw compare flags on the incoming operands.
  logic w_eq, w_lts, w_ltu;
  assign w_eq  = (a == b);
  assign w_lts = ($signed(a) < $signed(b));
  assign w_ltu = (a < b);

  // Source feeding the output register: the inputs directly (LATENCY=1)
  // or stage A (LATENCY=2).
  logic            w_s_valid;
  logic [XLEN-1:0] w_s_pc, w_s_target;
  logic            w_s_pred;
  logic [2:0]      w_s_cmpop;
  logic            w_s_eq, w_s_lts, w_s_ltu;

  logic            r_out_valid;
  logic            r_br_en, r_mispredict, r_illegal;
  logic [XLEN-1:0] r_redirect_pc;
  logic            w_out_adv;

  // Output register can take a new entry when empty or being drained.
  assign w_out_adv = !r_out_valid || out_ready;

  if (LATENCY == 1) begin : g_lat1
    assign w_s_valid  = in_valid;
    assign w_s_pc     = pc;
    assign w_s_target = target;
    assign w_s_pred   = pred_taken;
    assign w_s_cmpop  = cmpop;
    assign w_s_eq     = w_eq;
    assign w_s_lts    = w_lts;
    assign w_s_ltu    = w_ltu;
    assign in_ready   = w_out_adv;
  end else if (LATENCY == 2) begin : g_lat2
    logic            r_a_valid;
    logic [XLEN-1:0] r_a_pc, r_a_target;
    logic            r_a_pred;
    logic [2:0]      r_a_cmpop;
    logic            r_a_eq, r_a_lts, r_a_ltu;

    assign in_ready = !r_a_valid || w_out_adv;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_a_valid  <= 1'b0;
        r_a_pc     <= '0;
        r_a_target <= '0;
        r_a_pred   <= 1'b0;
        r_a_cmpop  <= '0;
        r_a_eq     <= 1'b0;
        r_a_lts    <= 1'b0;
        r_a_ltu    <= 1'b0;
      end else if (flush) begin
        r_a_valid <= 1'b0;
      end else if (in_ready) begin
        r_a_valid <= in_valid;
        if (in_valid) begin
          r_a_pc     <= pc;
          r_a_target <= target;
          r_a_pred   <= pred_taken;
          r_a_cmpop  <= cmpop;
          r_a_eq     <= w_eq;
          r_a_lts    <= w_lts;
          r_a_ltu    <= w_ltu;
        end
      end
    end

    assign w_s_valid  = r_a_valid;
    assign w_s_pc     = r_a_pc;
    assign w_s_target = r_a_target;
    assign w_s_pred   = r_a_pred;
    assign w_s_cmpop  = r_a_cmpop;
    assign w_s_eq     = r_a_eq;
    assign w_s_lts    = r_a_lts;
    assign w_s_ltu    = r_a_ltu;
  end else begin : g_bad_latency
    $error("br_resolve_pipe: LATENCY must be 1 or 2");
  end

  // Direction select and redirect formation.
  logic            w_br_en, w_illegal, w_mispredict;
  logic [XLEN-1:0] w_redirect;

  always_comb begin
    w_br_en   = 1'b0;
    w_illegal = 1'b0;
    case (w_s_cmpop)
      3'b000:  w_br_en = w_s_eq;
      3'b001:  w_br_en = !w_s_eq;
      3'b100:  w_br_en = w_s_lts;
      3'b101:  w_br_en = !w_s_lts;
      3'b110:  w_br_en = w_s_ltu;
      3'b111:  w_br_en = !w_s_ltu;
      default: w_illegal = 1'b1;
    endcase
    w_mispredict = !w_illegal && (w_br_en != w_s_pred);
    w_redirect   = w_br_en ? w_s_target : w_s_pc + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_br_en       <= 1'b0;
      r_mispredict  <= 1'b0;
      r_illegal     <= 1'b0;
      r_redirect_pc <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_out_adv) begin
      r_out_valid <= w_s_valid;
      if (w_s_valid) begin
        r_br_en       <= w_br_en;
        r_mispredict  <= w_mispredict;
        r_illegal     <= w_illegal;
        r_redirect_pc <= w_redirect;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign br_en       = r_br_en;
  assign mispredict  = r_mispredict;
  assign illegal     = r_illegal;
  assign redirect_pc = r_redirect_pc;

`ifdef BR_RESOLVE_STATS_EN
  logic        w_out_fire;
  logic [31:0] r_stat_branches, r_stat_mispredicts;

  // A transfer in a flush cycle is still a delivery and is counted.
  assign w_out_fire = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clear) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_out_fire) begin
      if (r_stat_branches != '1) r_stat_branches <= r_stat_branches + 32'd1;
      // r_mispredict is already forced low for illegal entries.
      if (r_mispredict && (r_stat_mispredicts != '1)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
